crp16_regfile_context_unit: RTL and testbench

Initiator side of the CRP16 register-file port protocol.
- Save: walks all registers through the read port (`a_select` → `a_val`) and streams them out over a valid/ready interface.
- Restore: accepts a valid/ready word stream and drives the write port (`write_select`/`write_val`/`write`) to reload every register.
- Sits beside the core datapath, muxed onto the register file; used for debug snapshots and context switch. The core stalls while `busy`=1.

---
 rtl/crp16_regfile_context_unit_pkg.sv | 14 +
 rtl/crp16_ctx_checksum.sv | 40 ++++
 rtl/crp16_regfile_context_unit.sv | 143 ++++++++++++++
 tb/tb_crp16_regfile_context_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crp16_regfile_context_unit_pkg.sv
// Shared state encoding and default sizing for the CRP16 register-file context unit.
package crp16_regfile_context_unit_pkg;

  localparam int unsigned CTX_NUM_REGS_DEF   = 8;
  localparam int unsigned CTX_DATA_WIDTH_DEF = 16;
  localparam int unsigned CTX_SEL_WIDTH_DEF  = 3;

  typedef enum logic [1:0] {
    CTX_IDLE    = 2'd0,
    CTX_SAVE    = 2'd1,
    CTX_RESTORE = 2'd2
  } ctx_state_e;

endpackage

// File: rtl/crp16_ctx_checksum.sv
// Clear/accumulate/compare adder for the context stream checksum word.
// Only built when CRP16_CTX_CHECKSUM_EN is defined.
`ifdef CRP16_CTX_CHECKSUM_EN
module crp16_ctx_checksum #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  accum,
  input  logic [DATA_WIDTH-1:0] add_val,
  input  logic [DATA_WIDTH-1:0] cmp_val,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  mismatch_c
);

  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (accum) begin
      sum_d = sum_q + add_val;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum        = sum_q;
  assign mismatch_c = (sum_q != cmp_val);

endmodule
`endif

// File: rtl/crp16_regfile_context_unit.sv
// Save/restore engine that walks the CRP16 register file over valid/ready streams.
// CRP16_CTX_CHECKSUM_EN appends/verifies a modular-sum checksum word.
module crp16_regfile_context_unit
  import crp16_regfile_context_unit_pkg::*;
#(
  parameter int unsigned NUM_REGS   = CTX_NUM_REGS_DEF,
  parameter int unsigned DATA_WIDTH = CTX_DATA_WIDTH_DEF,
  parameter int unsigned SEL_WIDTH  = CTX_SEL_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  save_req,
  input  logic                  restore_req,
  output logic                  busy,
  output logic                  done,
  output logic                  restore_error,
  output logic [SEL_WIDTH-1:0]  rf_a_select,
  input  logic [DATA_WIDTH-1:0] rf_a_val,
  output logic [DATA_WIDTH-1:0] rf_write_val,
  output logic [SEL_WIDTH-1:0]  rf_write_select,
  output logic                  rf_write,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready
);

  localparam int unsigned IDX_W = SEL_WIDTH + 1;
`ifdef CRP16_CTX_CHECKSUM_EN
  localparam int unsigned NUM_WORDS = NUM_REGS + 1;
`else
  localparam int unsigned NUM_WORDS = NUM_REGS;
`endif

  ctx_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  out_xfer_c, in_xfer_c, last_word_c, reg_word_c;
  logic [DATA_WIDTH-1:0] save_word_c;

  assign out_xfer_c  = (state_q == CTX_SAVE) && out_ready;
  assign in_xfer_c   = (state_q == CTX_RESTORE) && in_valid;
  assign last_word_c = (idx_q == IDX_W'(NUM_WORDS - 1));
  assign reg_word_c  = (idx_q < IDX_W'(NUM_REGS));

`ifdef CRP16_CTX_CHECKSUM_EN
  logic                  restore_error_q, restore_error_d;
  logic [DATA_WIDTH-1:0] ck_sum_c;
  logic                  ck_mismatch_c;

  // Sum is cleared while idle and folds in every register word moved either way.
  crp16_ctx_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_checksum (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (state_q == CTX_IDLE),
    .accum      ((out_xfer_c || in_xfer_c) && reg_word_c),
    .add_val    ((state_q == CTX_SAVE) ? rf_a_val : in_data),
    .cmp_val    (in_data),
    .sum        (ck_sum_c),
    .mismatch_c (ck_mismatch_c)
  );

  assign save_word_c   = ((state_q == CTX_SAVE) && !reg_word_c) ? ck_sum_c : rf_a_val;
  assign restore_error = restore_error_q;
`else
  assign save_word_c   = rf_a_val;
  assign restore_error = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef CRP16_CTX_CHECKSUM_EN
    restore_error_d = restore_error_q;
`endif
    case (state_q)
      CTX_IDLE: begin
        if (save_req) begin
          state_d = CTX_SAVE;
          idx_d   = '0;
        end else if (restore_req) begin
          state_d = CTX_RESTORE;
          idx_d   = '0;
`ifdef CRP16_CTX_CHECKSUM_EN
          restore_error_d = 1'b0;
`endif
        end
      end
      CTX_SAVE, CTX_RESTORE: begin
        if (out_xfer_c || in_xfer_c) begin
          idx_d = idx_q + IDX_W'(1);
          if (last_word_c) begin
            state_d = CTX_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
`ifdef CRP16_CTX_CHECKSUM_EN
          if (in_xfer_c && !reg_word_c && ck_mismatch_c) begin
            restore_error_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = CTX_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= CTX_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef CRP16_CTX_CHECKSUM_EN
      restore_error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef CRP16_CTX_CHECKSUM_EN
      restore_error_q <= restore_error_d;
`endif
    end
  end

  // Port strobes follow the current state; writes only on an accepted register word.
  assign busy            = (state_q != CTX_IDLE);
  assign done            = done_q;
  assign out_valid       = (state_q == CTX_SAVE);
  assign out_data        = save_word_c;
  assign rf_a_select     = (out_valid && reg_word_c) ? idx_q[SEL_WIDTH-1:0] : '0;
  assign in_ready        = (state_q == CTX_RESTORE);
  assign rf_write        = in_xfer_c && reg_word_c;
  assign rf_write_select = rf_write ? idx_q[SEL_WIDTH-1:0] : '0;
  assign rf_write_val    = rf_write ? in_data : '0;

endmodule

// File: tb/tb_crp16_regfile_context_unit.sv
// Directed bench for crp16_regfile_context_unit with a behavioural register file.
module tb_crp16_regfile_context_unit;

  localparam int NREG = 8;
`ifdef CRP16_CTX_CHECKSUM_EN
  localparam int NW = NREG + 1;
`else
  localparam int NW = NREG;
`endif

  logic        clock = 1'b0;
  logic        resetn, save_req, restore_req, out_ready, in_valid;
  logic        busy, done, restore_error, rf_write, out_valid, in_ready;
  logic [2:0]  rf_a_select, rf_write_select;
  logic [15:0] rf_a_val, rf_write_val, out_data, in_data;

  logic [15:0] rf [NREG];
  logic        pl_we;
  logic [2:0]  pl_sel;
  logic [15:0] pl_val;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rf_write) rf[rf_write_select] <= rf_write_val;
    else if (pl_we) rf[pl_sel] <= pl_val;
  end
  assign rf_a_val = rf[rf_a_select];

  crp16_regfile_context_unit dut (
    .clock(clock), .resetn(resetn), .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done), .restore_error(restore_error),
    .rf_a_select(rf_a_select), .rf_a_val(rf_a_val), .rf_write_val(rf_write_val),
    .rf_write_select(rf_write_select), .rf_write(rf_write),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  function automatic logic [15:0] ck_sum(input logic [15:0] base);
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 0; i < NREG; i++) s = s + base + 16'(i);
    return s;
  endfunction

  task automatic preload(input logic [15:0] base);
    for (int i = 0; i < NREG; i++) begin
      @(negedge clock);
      pl_we = 1'b1; pl_sel = 3'(i); pl_val = base + 16'(i);
    end
    @(negedge clock);
    pl_we = 1'b0;
  endtask

  task automatic run_save(input bit stall, input bit both, input logic [15:0] base);
    int widx, cyc;
    logic [15:0] exp_w;
    @(negedge clock);
    save_req = 1'b1; restore_req = both; out_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL save_req_cycle_busy: got %b want 0", busy); end
    @(negedge clock);
    widx = 0; cyc = 0;
    while (widx < NW && cyc < 200) begin
      save_req    = both && (widx < NW - 1);
      restore_req = both && (widx < NW - 1);
      out_ready   = stall ? (cyc % 3 == 0) : 1'b1;
      #1;
      exp_w = (widx < NREG) ? base + 16'(widx) : ck_sum(base);
      checks++;
      if ({busy, out_valid, in_ready, rf_write} !== 4'b1100) begin
        errors++;
        $display("FAIL save_strobes[%0d]: got busy/ov/ir/wr=%b want 1100", widx, {busy, out_valid, in_ready, rf_write});
      end
      checks++;
      if (out_data !== exp_w) begin
        errors++; $display("FAIL save_word[%0d]: got %h want %h", widx, out_data, exp_w);
      end
      if (out_ready) widx++;
      cyc++;
      @(negedge clock);
    end
    save_req = 1'b0; restore_req = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (widx != NW) begin errors++; $display("FAIL save_timeout: got %0d words want %0d", widx, NW); end
    if (!stall) begin
      checks++;
      if (cyc != NW) begin errors++; $display("FAIL save_busy_cycles: got %0d want %0d", cyc, NW); end
    end
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++; $display("FAIL save_done_pulse: got done/busy=%b want 10", {done, busy});
    end
    @(negedge clock); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL save_done_width: got %b want 0", done); end
  endtask

  task automatic run_restore(input logic [15:0] base, input int n_send, input bit gapped, input bit bad_ck);
    int widx, cyc;
    logic [15:0] word;
    bit exp_wr;
    @(negedge clock);
    restore_req = 1'b1;
    @(negedge clock);
    restore_req = 1'b0;
    widx = 0; cyc = 0;
    while (widx < n_send && cyc < 200) begin
      in_valid = gapped ? (cyc % 2 == 0) : 1'b1;
      word     = (widx < NREG) ? base + 16'(widx) : (bad_ck ? 16'h0000 : ck_sum(base));
      in_data  = in_valid ? word : 16'hDEAD;
      #1;
      exp_wr = in_valid && (widx < NREG);
      checks++;
      if ({busy, in_ready, out_valid} !== 3'b110) begin
        errors++; $display("FAIL restore_strobes[%0d]: got busy/ir/ov=%b want 110", widx, {busy, in_ready, out_valid});
      end
      checks++;
      if (rf_write !== exp_wr) begin
        errors++; $display("FAIL restore_wr_en[%0d]: got %b want %b", widx, rf_write, exp_wr);
      end
      if (exp_wr) begin
        checks++;
        if (rf_write_select !== 3'(widx) || rf_write_val !== word) begin
          errors++;
          $display("FAIL restore_wr_port[%0d]: got sel=%0d val=%h want sel=%0d val=%h",
                   widx, rf_write_select, rf_write_val, widx, word);
        end
      end
      if (in_valid) widx++;
      cyc++;
      @(negedge clock);
    end
    in_valid = 1'b0; in_data = 16'h0000;
    checks++;
    if (widx != n_send) begin errors++; $display("FAIL restore_timeout: got %0d words want %0d", widx, n_send); end
  endtask

  task automatic test_reset();
    resetn = 1'b0; save_req = 1'b0; restore_req = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_data = 16'h0000; pl_we = 1'b0; pl_sel = 3'd0; pl_val = 16'h0000;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({busy, done, out_valid, in_ready, rf_write, restore_error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000", {busy, done, out_valid, in_ready, rf_write, restore_error});
    end
    checks++;
    if (rf_a_select !== 3'd0 || rf_write_select !== 3'd0 || rf_write_val !== 16'h0000) begin
      errors++;
      $display("FAIL reset_ports: got asel=%0d wsel=%0d wval=%h want 0 0 0000", rf_a_select, rf_write_select, rf_write_val);
    end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_save();
    preload(16'h1000);
    run_save(1'b0, 1'b0, 16'h1000);
  endtask

  task automatic test_save_stall();
    run_save(1'b1, 1'b0, 16'h1000);
  endtask

  task automatic test_restore();
    run_restore(16'hA0A0, NW, 1'b1, 1'b0);
    #1;
    checks++;
    if ({done, busy, restore_error} !== 3'b100) begin
      errors++; $display("FAIL restore_done: got done/busy/err=%b want 100", {done, busy, restore_error});
    end
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (rf[i] !== 16'hA0A0 + 16'(i)) begin
        errors++; $display("FAIL restore_reg[%0d]: got %h want %h", i, rf[i], 16'hA0A0 + 16'(i));
      end
    end
    @(negedge clock); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL restore_done_width: got %b want 0", done); end
  endtask

  task automatic test_both_req();
    run_save(1'b0, 1'b1, 16'hA0A0);
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (rf[i] !== 16'hA0A0 + 16'(i)) begin
        errors++; $display("FAIL both_req_reg[%0d]: got %h want %h", i, rf[i], 16'hA0A0 + 16'(i));
      end
    end
  endtask

  task automatic test_reset_abort();
    run_restore(16'hB0B0, 3, 1'b0, 1'b0);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    #1;
    checks++;
    if ({busy, done, rf_write, in_ready} !== 4'b0000) begin
      errors++; $display("FAIL abort_idle: got busy/done/wr/ir=%b want 0000", {busy, done, rf_write, in_ready});
    end
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (rf[i] !== ((i < 3) ? 16'hB0B0 + 16'(i) : 16'hA0A0 + 16'(i))) begin
        errors++;
        $display("FAIL abort_reg[%0d]: got %h want %h", i, rf[i], (i < 3) ? 16'hB0B0 + 16'(i) : 16'hA0A0 + 16'(i));
      end
    end
    @(negedge clock); #1;
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL abort_no_done: got done/busy=%b want 00", {done, busy});
    end
  endtask

`ifdef CRP16_CTX_CHECKSUM_EN
  task automatic test_checksum();
    run_restore(16'h0001, NW, 1'b0, 1'b1);
    #1;
    checks++;
    if ({done, restore_error} !== 2'b11) begin
      errors++; $display("FAIL ck_bad_restore: got done/err=%b want 11", {done, restore_error});
    end
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (rf[i] !== 16'h0001 + 16'(i)) begin
        errors++; $display("FAIL ck_reg[%0d]: got %h want %h", i, rf[i], 16'h0001 + 16'(i));
      end
    end
    run_save(1'b0, 1'b0, 16'h0001);
    checks++;
    if (restore_error !== 1'b1) begin errors++; $display("FAIL ck_sticky: got %b want 1", restore_error); end
    run_restore(16'h0001, NW, 1'b0, 1'b0);
    #1;
    checks++;
    if (restore_error !== 1'b0) begin errors++; $display("FAIL ck_good_restore: got %b want 0", restore_error); end
  endtask
`endif

  initial begin
    test_reset();
    test_save();
    test_save_stall();
    test_restore();
    test_both_req();
    test_reset_abort();
`ifdef CRP16_CTX_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
